pipeline_hazard_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RISC-V pipeline.
//  - Drives STALL/DUMP into Fetch_Decode and Decode_Execute pipeline registers, plus the PC hold.
//  - Scoreboards in-flight register writes, so decode stalls on RAW hazards (no forwarding).
//  - Runs a flush FSM that squashes wrong-path instructions after a taken branch/jump resolves in execute.
//  - Keeps saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_controller_if.sv | 31 +++
 rtl/pipeline_hazard_controller.sv | 102 ++++++++++
 tb/tb_pipeline_hazard_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Decode/execute hazard-control bundle shared between the pipeline datapath
// and the hazard controller.
interface pipeline_hazard_controller_if;
  logic        valid_Decode;
  logic [4:0]  rs1_Decode;
  logic        rs1_used_Decode;
  logic [4:0]  rs2_Decode;
  logic        rs2_used_Decode;
  logic [4:0]  writeback_Reg_Decode;
  logic        reg_wEn_Decode;
  logic        next_PC_select_Execute;
  logic        PC_hold;
  logic        STALL_FD;
  logic        DUMP_FD;
  logic        DUMP_DE;
  logic        flush_active;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output valid_Decode, rs1_Decode, rs1_used_Decode, rs2_Decode, rs2_used_Decode,
           writeback_Reg_Decode, reg_wEn_Decode, next_PC_select_Execute,
    input  PC_hold, STALL_FD, DUMP_FD, DUMP_DE, flush_active, stall_count, flush_count
  );

  modport slave (
    input  valid_Decode, rs1_Decode, rs1_used_Decode, rs2_Decode, rs2_used_Decode,
           writeback_Reg_Decode, reg_wEn_Decode, next_PC_select_Execute,
    output PC_hold, STALL_FD, DUMP_FD, DUMP_DE, flush_active, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW scoreboard without
// forwarding, redirect flush FSM and saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int WB_LATENCY   = 3,
  parameter int FLUSH_CYCLES = 1
) (
  input logic                          clock,
  input logic                          reset,
  pipeline_hazard_controller_if.slave  hz
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                       state;
  logic [2:0]                   fcnt;
  logic [WB_LATENCY-1:0]        sb_valid;
  logic [WB_LATENCY-1:0][4:0]   sb_rd;
  logic [15:0]                  stall_count_q;
  logic [15:0]                  flush_count_q;
  logic                         rs1_match;
  logic                         rs2_match;
  logic                         hazard;
  logic                         redirect;
  logic                         flush_now;
  logic                         issue;

  // The oldest entry is still compared: its regfile write only lands at the edge.
  always_comb begin
    rs1_match = 1'b0;
    rs2_match = 1'b0;
    for (int i = 0; i < WB_LATENCY; i++) begin
      if (sb_valid[i] && (sb_rd[i] == hz.rs1_Decode)) rs1_match = 1'b1;
      if (sb_valid[i] && (sb_rd[i] == hz.rs2_Decode)) rs2_match = 1'b1;
    end
  end

  assign hazard = hz.valid_Decode &
                  ((hz.rs1_used_Decode & (hz.rs1_Decode != 5'd0) & rs1_match) |
                   (hz.rs2_used_Decode & (hz.rs2_Decode != 5'd0) & rs2_match));
  assign redirect  = (state == RUN) & hz.next_PC_select_Execute;
  assign flush_now = (state == FLUSH) | redirect;
  assign issue     = hz.valid_Decode & hz.reg_wEn_Decode &
                     (hz.writeback_Reg_Decode != 5'd0) & ~hazard & ~flush_now;

  always_comb begin
    hz.PC_hold  = 1'b0;
    hz.STALL_FD = 1'b0;
    hz.DUMP_FD  = 1'b0;
    hz.DUMP_DE  = 1'b0;
    if (reset || flush_now) begin
      hz.DUMP_FD = 1'b1;
      hz.DUMP_DE = 1'b1;
    end else if (hazard) begin
      hz.PC_hold  = 1'b1;
      hz.STALL_FD = 1'b1;
      hz.DUMP_DE  = 1'b1;
    end
  end

  assign hz.flush_active = (state == FLUSH);
  assign hz.stall_count  = stall_count_q;
  assign hz.flush_count  = flush_count_q;

  // During FLUSH execute holds a bubble, so a repeated redirect is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      fcnt          <= 3'd0;
      sb_valid      <= '0;
      sb_rd         <= '0;
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      for (int i = 1; i < WB_LATENCY; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_rd[i]    <= sb_rd[i-1];
      end
      sb_valid[0] <= issue;
      sb_rd[0]    <= issue ? hz.writeback_Reg_Decode : 5'd0;

      case (state)
        RUN: begin
          if (redirect && (FLUSH_CYCLES > 1)) begin
            state <= FLUSH;
            fcnt  <= 3'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          fcnt <= fcnt - 3'd1;
          if (fcnt == 3'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase

      if (hazard && !flush_now && (stall_count_q != 16'hFFFF))
        stall_count_q <= stall_count_q + 16'd1;
      if (redirect && (flush_count_q != 16'hFFFF))
        flush_count_q <= flush_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (WB_LATENCY=3, FLUSH_CYCLES=2);
// inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_pipeline_hazard_controller;

  logic clock;
  logic reset;
  int   check_count;
  int   error_count;

  pipeline_hazard_controller_if hz ();

  pipeline_hazard_controller #(
    .WB_LATENCY  (3),
    .FLUSH_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hz   (hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic rst, input logic valid,
                               input logic [4:0] rs1, input logic rs1u,
                               input logic [4:0] rs2, input logic rs2u,
                               input logic [4:0] rd, input logic wen,
                               input logic sel);
    reset                     = rst;
    hz.valid_Decode           = valid;
    hz.rs1_Decode             = rs1;
    hz.rs1_used_Decode        = rs1u;
    hz.rs2_Decode             = rs2;
    hz.rs2_used_Decode        = rs2u;
    hz.writeback_Reg_Decode   = rd;
    hz.reg_wEn_Decode         = wen;
    hz.next_PC_select_Execute = sel;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkControls(input string tag, input logic hold, input logic stall,
                               input logic dfd, input logic dde);
    checkOutput({tag, ".PC_hold"},  {15'd0, hz.PC_hold},  {15'd0, hold});
    checkOutput({tag, ".STALL_FD"}, {15'd0, hz.STALL_FD}, {15'd0, stall});
    checkOutput({tag, ".DUMP_FD"},  {15'd0, hz.DUMP_FD},  {15'd0, dfd});
    checkOutput({tag, ".DUMP_DE"},  {15'd0, hz.DUMP_DE},  {15'd0, dde});
  endtask

  task automatic nextCycle;
    @(posedge clock);
    #1;
  endtask

  initial begin
    check_count = 0;
    error_count = 0;

    // Reset for two edges while a writing, hazard-looking instruction and a redirect are present
    applyStimulus(1, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1);
    @(negedge clock);
    checkControls("rst1", 0, 0, 1, 1);
    nextCycle();
    @(negedge clock);
    checkControls("rst2", 0, 0, 1, 1);
    checkOutput("rst2.stall_count", hz.stall_count, 16'd0);
    checkOutput("rst2.flush_count", hz.flush_count, 16'd0);
    checkOutput("rst2.flush_active", {15'd0, hz.flush_active}, 16'd0);
    nextCycle();
    applyStimulus(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clock);
    checkControls("rel", 0, 0, 0, 0);
    checkOutput("rel.stall_count", hz.stall_count, 16'd0);
    nextCycle();

    // Back-to-back RAW on x5 stalls exactly three cycles
    applyStimulus(0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
    @(negedge clock);
    checkControls("raw.issue", 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checkControls($sformatf("raw.stall%0d", c), 1, 1, 0, 1);
      nextCycle();
    end
    @(negedge clock);
    checkControls("raw.go", 0, 0, 0, 0);
    checkOutput("raw.stall_count", hz.stall_count, 16'd3);
    nextCycle();

    // x0 never hazards; unused rs2 ignored; used rs2 does hazard
    applyStimulus(0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    @(negedge clock);
    checkControls("x0.issue", 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clock);
    checkControls("x0.read", 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0);
    @(negedge clock);
    checkControls("r7.issue", 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 1, 5'd0, 0, 5'd7, 0, 5'd0, 0, 0);
    @(negedge clock);
    checkControls("r7.unused", 0, 0, 0, 0);
    checkOutput("r7.stall_count", hz.stall_count, 16'd3);
    nextCycle();
    applyStimulus(0, 1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0);
    @(negedge clock);
    checkControls("r7.used", 1, 1, 0, 1);
    nextCycle();
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    repeat (3) nextCycle();

    // Redirect held two cycles: two dump cycles, one FLUSH cycle, one count
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
    @(negedge clock);
    checkControls("fl.c0", 0, 0, 1, 1);
    checkOutput("fl.c0.flush_active", {15'd0, hz.flush_active}, 16'd0);
    checkOutput("fl.c0.stall_count", hz.stall_count, 16'd4);
    nextCycle();
    @(negedge clock);
    checkControls("fl.c1", 0, 0, 1, 1);
    checkOutput("fl.c1.flush_active", {15'd0, hz.flush_active}, 16'd1);
    nextCycle();
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clock);
    checkControls("fl.c2", 0, 0, 0, 0);
    checkOutput("fl.c2.flush_active", {15'd0, hz.flush_active}, 16'd0);
    checkOutput("fl.c2.flush_count", hz.flush_count, 16'd1);
    nextCycle();

    // Redirect during a stall overrides it; wrong-path writes are not recorded
    applyStimulus(0, 1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
    @(negedge clock);
    checkControls("sq.issue", 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    @(negedge clock);
    checkControls("sq.stall", 1, 1, 0, 1);
    nextCycle();
    applyStimulus(0, 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 1);
    @(negedge clock);
    checkControls("sq.redirect", 0, 0, 1, 1);
    checkOutput("sq.redirect.stall_count", hz.stall_count, 16'd5);
    nextCycle();
    applyStimulus(0, 1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 0);
    @(negedge clock);
    checkControls("sq.flush", 0, 0, 1, 1);
    checkOutput("sq.flush.flush_active", {15'd0, hz.flush_active}, 16'd1);
    nextCycle();
    applyStimulus(0, 1, 5'd6, 1, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clock);
    checkControls("sq.after", 0, 0, 0, 0);
    checkOutput("sq.after.stall_count", hz.stall_count, 16'd5);
    checkOutput("sq.after.flush_count", hz.flush_count, 16'd2);
    nextCycle();

    // Reset mid-flush with x9 pending in the scoreboard
    applyStimulus(0, 1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
    @(negedge clock);
    checkControls("rf.issue", 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
    @(negedge clock);
    checkControls("rf.redirect", 0, 0, 1, 1);
    nextCycle();
    applyStimulus(1, 1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clock);
    checkControls("rf.reset", 0, 0, 1, 1);
    nextCycle();
    applyStimulus(0, 1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clock);
    checkControls("rf.after", 0, 0, 0, 0);
    checkOutput("rf.after.flush_active", {15'd0, hz.flush_active}, 16'd0);
    checkOutput("rf.after.stall_count", hz.stall_count, 16'd0);
    checkOutput("rf.after.flush_count", hz.flush_count, 16'd0);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
